chip_ram_sched: RTL and testbench

- Port-B scheduler for the 4096x8 dual-port CHIP-8 memory (port A stays with the CPU fetch path).
- Shares port B between three requesters:
  - host loader: single-byte ROM load and readback;
  - CPU block transfer: FX55 store / FX65 load of V0..Vx at I;
  - sprite fetch: n bytes from I for the draw engine.
- Sequences multi-byte bursts around the RAM's 1-cycle read latency.

---
 rtl/chip_ram_sched_pkg.sv | 32 +++
 rtl/chip_ram_sched_if.sv | 75 +++++++
 rtl/chip_ram_sched_burst.sv | 61 ++++++
 rtl/chip_ram_sched.sv | 167 ++++++++++++++++
 tb/tb_chip_ram_sched.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/chip_ram_sched_pkg.sv
// -----------------------------------------------------------------------------
// chip_pkg
// Shared types and sizes for the CHIP-8 RAM port-B scheduler.
//   sched_state_t : scheduler FSM states
//   burst_kind_t  : which requester owns the current burst (selects what DRAIN emits)
//   ADDR_W/DATA_W/CNT_W/MEM_DEPTH : memory geometry and burst-length field width
// -----------------------------------------------------------------------------
package chip_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 8;
    localparam int CNT_W     = 4;
    localparam int MEM_DEPTH = 4096;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST,
        S_HOST_RSP,
        S_BLK_ST,
        S_BLK_LD,
        S_SPR,
        S_DRAIN
    } sched_state_t;

    typedef enum logic [1:0] {
        K_NONE,
        K_ST,
        K_LD,
        K_SPR
    } burst_kind_t;

endpackage

// File: rtl/chip_ram_sched_if.sv
// -----------------------------------------------------------------------------
// chip_ram_sched_if
// Bundles every signal of the port-B scheduler except clk/reset.
//   modport slave  : the scheduler's view
//   modport master : the requesters' / RAM's / register file's view
// Optional macro CHIP8_QUIRK_I_INCR_EN adds i_upd_valid / i_upd.
// -----------------------------------------------------------------------------
interface chip_ram_sched_if import chip_pkg::*; #(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W,
    parameter int CW = CNT_W
);
    logic          host_req, host_we, host_ack;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;

    logic          blk_req, blk_store, blk_done;
    logic [AW-1:0] blk_base;
    logic [CW-1:0] blk_last;

    logic [CW-1:0] reg_ridx, reg_widx;
    logic [DW-1:0] reg_rdata, reg_wdata;
    logic          reg_we;

    logic          spr_req, spr_valid, spr_done;
    logic [AW-1:0] spr_base;
    logic [CW-1:0] spr_len;
    logic [DW-1:0] spr_data;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          ram_we;

    logic          busy;

`ifdef CHIP8_QUIRK_I_INCR_EN
    logic          i_upd_valid;
    logic [AW-1:0] i_upd;
`endif

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        input  blk_req, blk_store, blk_base, blk_last,
        output blk_done,
        output reg_ridx, reg_we, reg_widx, reg_wdata,
        input  reg_rdata,
        input  spr_req, spr_base, spr_len,
        output spr_valid, spr_data, spr_done,
        output ram_addr, ram_wdata, ram_we,
        input  ram_rdata,
`ifdef CHIP8_QUIRK_I_INCR_EN
        output i_upd_valid, i_upd,
`endif
        output busy
    );

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        output blk_req, blk_store, blk_base, blk_last,
        input  blk_done,
        input  reg_ridx, reg_we, reg_widx, reg_wdata,
        output reg_rdata,
        output spr_req, spr_base, spr_len,
        input  spr_valid, spr_data, spr_done,
        input  ram_addr, ram_wdata, ram_we,
        output ram_rdata,
`ifdef CHIP8_QUIRK_I_INCR_EN
        input  i_upd_valid, i_upd,
`endif
        input  busy
    );

endinterface

// File: rtl/chip_ram_sched_burst.sv
// -----------------------------------------------------------------------------
// chip_ram_burst
// Byte counter plus one-stage read pipeline shared by every burst.
//   clr_i    : force counter to 0 (scheduler idle)
//   step_i   : advance counter by one byte
//   rd_i     : a read address is on the RAM this cycle
//   base_i   : latched burst start address
//   last_i   : latched index of the final byte
//   addr_o   : base_i + counter, wrapping modulo 2^ADDR_W
//   cnt_o    : current byte index
//   is_last_o: current byte is the final one
//   pv_o     : RAM q holds the byte requested last cycle
//   pidx_o   : index of that byte
// -----------------------------------------------------------------------------
module chip_ram_burst import chip_pkg::*; #(
    parameter int AW = ADDR_W,
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          step_i,
    input  logic          rd_i,
    input  logic [AW-1:0] base_i,
    input  logic [CW-1:0] last_i,
    output logic [AW-1:0] addr_o,
    output logic [CW-1:0] cnt_o,
    output logic          is_last_o,
    output logic          pv_o,
    output logic [CW-1:0] pidx_o
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pv_q;
    logic [CW-1:0] pidx_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)       cnt_d = '0;
        else if (step_i) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            pv_q   <= 1'b0;
            pidx_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            // The RAM answers one cycle late, so the index travels with it.
            pv_q   <= rd_i;
            pidx_q <= cnt_q;
        end
    end

    assign addr_o    = base_i + AW'(cnt_q);
    assign cnt_o     = cnt_q;
    assign is_last_o = (cnt_q == last_i);
    assign pv_o      = pv_q;
    assign pidx_o    = pidx_q;

endmodule

// File: rtl/chip_ram_sched.sv
// -----------------------------------------------------------------------------
// chip_ram_sched
// Port-B scheduler for the 4096x8 CHIP-8 RAM. Arbitrates host loader,
// FX55/FX65 block transfers and sprite fetches (priority host > blk > spr,
// decided only in IDLE, bursts non-preemptive).
//   clk, reset : system clock, synchronous active-high reset
//   bus        : chip_ram_sched_if.slave (host_*, blk_*, reg_*, spr_*, ram_*, busy)
// Optional macro CHIP8_QUIRK_I_INCR_EN: drives i_upd_valid/i_upd with
// blk_base+blk_last+1 on blk_done (COSMAC I-increment).
// -----------------------------------------------------------------------------
module chip_ram_sched import chip_pkg::*; #(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W,
    parameter int CW = CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    chip_ram_sched_if.slave   bus
);
    sched_state_t  state_q, state_d;
    burst_kind_t   kind_q;
    logic [AW-1:0] base_q;
    logic [CW-1:0] last_q;
    logic [AW-1:0] host_addr_q;
    logic [DW-1:0] host_wdata_q;
    logic          host_we_q;

    logic [AW-1:0] b_addr;
    logic [CW-1:0] b_cnt, b_pidx;
    logic          b_last, b_pv;

    logic in_burst, in_read;
    assign in_burst = (state_q == S_BLK_ST) || (state_q == S_BLK_LD) || (state_q == S_SPR);
    assign in_read  = (state_q == S_BLK_LD) || (state_q == S_SPR);

    chip_ram_burst #(.AW(AW), .CW(CW)) u_burst (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (state_q == S_IDLE),
        .step_i   (in_burst),
        .rd_i     (in_read),
        .base_i   (base_q),
        .last_i   (last_q),
        .addr_o   (b_addr),
        .cnt_o    (b_cnt),
        .is_last_o(b_last),
        .pv_o     (b_pv),
        .pidx_o   (b_pidx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: state is updated with <= so every flop samples pre-edge values.
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are captured at grant only; later changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q       <= K_NONE;
            base_q       <= '0;
            last_q       <= '0;
            host_addr_q  <= '0;
            host_wdata_q <= '0;
            host_we_q    <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (bus.host_req) begin
                host_addr_q  <= bus.host_addr;
                host_wdata_q <= bus.host_wdata;
                host_we_q    <= bus.host_we;
            end else if (bus.blk_req) begin
                kind_q <= bus.blk_store ? K_ST : K_LD;
                base_q <= bus.blk_base;
                last_q <= bus.blk_last;
            end else if (bus.spr_req) begin
                kind_q <= K_SPR;
                base_q <= bus.spr_base;
                last_q <= (bus.spr_len == '0) ? '0 : bus.spr_len - CW'(1);
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_d        = state_q;
        bus.host_ack   = 1'b0;
        bus.host_rdata = '0;
        bus.blk_done   = 1'b0;
        bus.reg_ridx   = '0;
        bus.reg_we     = 1'b0;
        bus.reg_widx   = '0;
        bus.reg_wdata  = '0;
        bus.spr_valid  = 1'b0;
        bus.spr_data   = '0;
        bus.spr_done   = 1'b0;
        bus.ram_addr   = '0;
        bus.ram_wdata  = '0;
        bus.ram_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.host_req)     state_d = S_HOST;
                else if (bus.blk_req) state_d = bus.blk_store ? S_BLK_ST : S_BLK_LD;
                else if (bus.spr_req) state_d = S_SPR;
            end
            S_HOST: begin
                bus.ram_addr  = host_addr_q;
                bus.ram_wdata = host_wdata_q;
                bus.ram_we    = host_we_q;
                state_d       = S_HOST_RSP;
            end
            S_HOST_RSP: begin
                bus.host_ack   = 1'b1;
                // A write acknowledges with the data it wrote.
                bus.host_rdata = host_we_q ? host_wdata_q : bus.ram_rdata;
                state_d        = S_IDLE;
            end
            S_BLK_ST: begin
                bus.reg_ridx  = b_cnt;
                bus.ram_addr  = b_addr;
                bus.ram_wdata = bus.reg_rdata;
                bus.ram_we    = 1'b1;
                if (b_last) state_d = S_DRAIN;
            end
            S_BLK_LD, S_SPR: begin
                bus.ram_addr = b_addr;
                if (state_q == S_BLK_LD) begin
                    bus.reg_we    = b_pv;
                    bus.reg_widx  = b_pv ? b_pidx : '0;
                    bus.reg_wdata = b_pv ? bus.ram_rdata : '0;
                end else begin
                    bus.spr_valid = b_pv;
                    bus.spr_data  = b_pv ? bus.ram_rdata : '0;
                end
                if (b_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Emits the byte fetched by the final address, plus completion.
                if (kind_q == K_SPR) begin
                    bus.spr_valid = b_pv;
                    bus.spr_data  = b_pv ? bus.ram_rdata : '0;
                    bus.spr_done  = 1'b1;
                end else begin
                    bus.blk_done = 1'b1;
                    if (kind_q == K_LD) begin
                        bus.reg_we    = b_pv;
                        bus.reg_widx  = b_pv ? b_pidx : '0;
                        bus.reg_wdata = b_pv ? bus.ram_rdata : '0;
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = (state_q != S_IDLE);

`ifdef CHIP8_QUIRK_I_INCR_EN
    assign bus.i_upd_valid = bus.blk_done;
    assign bus.i_upd       = base_q + AW'(last_q) + AW'(1);
`endif

endmodule

// File: tb/tb_chip_ram_sched.sv
// -----------------------------------------------------------------------------
// tb_chip_ram_sched
// Scoreboard bench for chip_ram_sched: stimulus pushes expected RAM writes,
// register writes, host responses, sprite bytes and completions into queues;
// a negedge monitor pops and compares whenever the DUT strobes an output.
// Includes a 4096x8 RAM model (1-cycle read latency) and a register file.
// Build with CHIP8_QUIRK_I_INCR_EN to also check i_upd on blk_done.
// -----------------------------------------------------------------------------
module tb_chip_ram_sched;
    import chip_pkg::*;

    typedef struct packed { logic [11:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic [3:0] idx; logic [7:0] data; }  rw_t;
    typedef struct packed { logic [7:0] data; logic last; }        sp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    chip_ram_sched_if bus ();

    chip_ram_sched dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // RAM and register-file models
    logic [7:0] mem  [MEM_DEPTH];
    logic [7:0] regv [16];

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end
    assign bus.reg_rdata = regv[bus.reg_ridx];

    int checks = 0;
    int errors = 0;
    int spr_seen = 0;

    wr_t        wr_q[$];
    rw_t        rw_q[$];
    sp_t        sp_q[$];
    logic [7:0] host_q[$];
    logic [11:0] done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got strobe with nothing expected", name);
    endtask

    // Monitor: consumes expectations as the DUT presents outputs.
    always @(negedge clk) begin
        wr_t         w;
        rw_t         r;
        sp_t         s;
        logic [11:0] iu;
        if (bus.ram_we) begin
            if (wr_q.size() == 0) unexpected("ram_we");
            else begin
                w = wr_q.pop_front();
                check("ram_waddr", 32'(bus.ram_addr), 32'(w.addr));
                check("ram_wdata", 32'(bus.ram_wdata), 32'(w.data));
            end
        end
        if (bus.host_ack) begin
            if (host_q.size() == 0) unexpected("host_ack");
            else check("host_rdata", 32'(bus.host_rdata), 32'(host_q.pop_front()));
        end
        if (bus.reg_we) begin
            if (rw_q.size() == 0) unexpected("reg_we");
            else begin
                r = rw_q.pop_front();
                check("reg_widx", 32'(bus.reg_widx), 32'(r.idx));
                check("reg_wdata", 32'(bus.reg_wdata), 32'(r.data));
            end
        end
        if (bus.spr_valid) begin
            spr_seen++;
            if (sp_q.size() == 0) unexpected("spr_valid");
            else begin
                s = sp_q.pop_front();
                check("spr_data", 32'(bus.spr_data), 32'(s.data));
                check("spr_done", 32'(bus.spr_done), 32'(s.last));
            end
        end else if (bus.spr_done) unexpected("spr_done_alone");
        if (bus.blk_done) begin
            if (done_q.size() == 0) unexpected("blk_done");
            else begin
                iu = done_q.pop_front();
`ifdef CHIP8_QUIRK_I_INCR_EN
                check("i_upd_valid", 32'(bus.i_upd_valid), 32'd1);
                check("i_upd", 32'(bus.i_upd), 32'(iu));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_op(input logic we, input logic [11:0] a, input logic [7:0] d,
                           input logic [7:0] exp_rd);
        int n;
        if (we) wr_q.push_back('{addr: a, data: d});
        host_q.push_back(exp_rd);
        bus.host_req   = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = a;
        bus.host_wdata = d;
        n = 0;
        while (!bus.host_ack && n < 10) begin tick(); n++; end
        check("host_latency", 32'(n), 32'd2);
        bus.host_req = 1'b0;
        tick();
    endtask

    task automatic blk_op(input logic st, input logic [11:0] base, input logic [3:0] x);
        int n;
        bus.blk_req   = 1'b1;
        bus.blk_store = st;
        bus.blk_base  = base;
        bus.blk_last  = x;
        n = 0;
        while (!bus.blk_done && n < 40) begin tick(); n++; end
        check(st ? "fx55_done_cycle" : "fx65_done_cycle", 32'(n), 32'(x) + 32'd2);
        bus.blk_req = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        logic [7:0] sprite [5];
        sprite[0] = 8'hF0; sprite[1] = 8'h90; sprite[2] = 8'h90;
        sprite[3] = 8'h90; sprite[4] = 8'hF0;

        reset = 1'b1;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.blk_req = 1'b0; bus.blk_store = 1'b0; bus.blk_base = '0; bus.blk_last = '0;
        bus.spr_req = 1'b0; bus.spr_base = '0; bus.spr_len = '0;
        for (int i = 0; i < 16; i++) regv[i] = 8'h00;

        // Reset state, with requests pending to prove they are held off.
        bus.host_req = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_strobes", {26'd0, bus.host_ack, bus.blk_done, bus.reg_we,
                              bus.spr_valid, bus.spr_done, bus.ram_we}, 32'd0);
        bus.host_req = 1'b0;
        reset = 1'b0;
        tick();

        // Host write then readback.
        host_op(1'b1, 12'h200, 8'hAB, 8'hAB);
        host_op(1'b0, 12'h200, 8'h00, 8'hAB);

        // FX55: V0..V3 -> 0x300..0x303.
        regv[0] = 8'h11; regv[1] = 8'h22; regv[2] = 8'h33; regv[3] = 8'h44;
        for (int k = 0; k < 4; k++)
            wr_q.push_back('{addr: 12'h300 + 12'(k), data: regv[k]});
        done_q.push_back(12'h304);
        blk_op(1'b1, 12'h300, 4'd3);

        // FX65 across the top of memory.
        host_op(1'b1, 12'hFFE, 8'h01, 8'h01);
        host_op(1'b1, 12'hFFF, 8'h02, 8'h02);
        host_op(1'b1, 12'h000, 8'h03, 8'h03);
        rw_q.push_back('{idx: 4'd0, data: 8'h01});
        rw_q.push_back('{idx: 4'd1, data: 8'h02});
        rw_q.push_back('{idx: 4'd2, data: 8'h03});
        done_q.push_back(12'h001);
        blk_op(1'b0, 12'hFFE, 4'd2);

        // Sprite glyph "0" at 0x050.
        for (int k = 0; k < 5; k++) host_op(1'b1, 12'h050 + 12'(k), sprite[k], sprite[k]);

        // Sprite and host request together: host wins.
        for (int k = 0; k < 5; k++) sp_q.push_back('{data: sprite[k], last: (k == 4)});
        host_q.push_back(8'hAB);
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 12'h200;
        bus.spr_req  = 1'b1; bus.spr_base = 12'h050; bus.spr_len = 4'd5;
        n = 0;
        while (!bus.host_ack && n < 10) begin tick(); n++; end
        check("arb_host_latency", 32'(n), 32'd2);
        check("arb_spr_held_off", 32'(spr_seen), 32'd0);
        bus.host_req = 1'b0;
        tick();
        tick();
        // Burst is granted: changing or dropping the request has no effect.
        bus.spr_req = 1'b0; bus.spr_base = 12'h123; bus.spr_len = 4'd1;
        n = 0;
        while (!bus.spr_done && n < 20) begin tick(); n++; end
        check("spr_done_cycle", 32'(n), 32'd5);
        tick();
        check("spr_byte_count", 32'(spr_seen), 32'd5);
        check("spr_idle_busy", 32'(bus.busy), 32'd0);

        // spr_len = 0 fetches one byte.
        sp_q.push_back('{data: 8'hF0, last: 1'b1});
        bus.spr_req = 1'b1; bus.spr_base = 12'h050; bus.spr_len = 4'd0;
        n = 0;
        while (!bus.spr_done && n < 20) begin tick(); n++; end
        check("spr_len0_cycle", 32'(n), 32'd2);
        bus.spr_req = 1'b0;
        tick();

        // Reset in the 2nd cycle of a 16-byte FX55.
        for (int i = 0; i < 16; i++) regv[i] = 8'hA0 + 8'(i);
        wr_q.push_back('{addr: 12'h400, data: 8'hA0});
        wr_q.push_back('{addr: 12'h401, data: 8'hA1});
        bus.blk_req = 1'b1; bus.blk_store = 1'b1; bus.blk_base = 12'h400; bus.blk_last = 4'd15;
        tick();
        tick();
        reset = 1'b1;
        bus.blk_req = 1'b0;
        tick();
        reset = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_ram_we", 32'(bus.ram_we), 32'd0);
        repeat (3) begin
            tick();
            check("midrst_quiet", {30'd0, bus.ram_we, bus.busy}, 32'd0);
        end

        // Every expected event was observed.
        check("left_wr", 32'(wr_q.size()), 32'd0);
        check("left_rw", 32'(rw_q.size()), 32'd0);
        check("left_spr", 32'(sp_q.size()), 32'd0);
        check("left_host", 32'(host_q.size()), 32'd0);
        check("left_done", 32'(done_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
